// File: rtl/axil_ordered_address_router.sv
// AXI-lite address router: registered priority decode onto NS slaves plus an
// error slave, a 1-entry skid buffer for full throughput, a response-ordering
// gate that refuses a target switch while responses are outstanding, and a
// saturating decode-error counter.
module axil_ordered_address_router #(
    parameter int                      NS              = 4,
    parameter int                      AW              = 32,
    parameter int                      DW              = 38,
    parameter logic [NS-1:0][AW-1:0]   SLAVE_ADDR      = '0,
    parameter logic [NS-1:0][AW-1:0]   SLAVE_MASK      = '0,
    parameter logic [NS-1:0]           ACCESS_ALLOWED  = '1,
    parameter int                      MAX_OUTSTANDING = 4,
    parameter int                      ERR_CNT_W       = 16,
    localparam int                     IW              = $clog2(NS+1),
    localparam int                     CW              = $clog2(MAX_OUTSTANDING+1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_valid,
    output logic                 o_stall,
    input  logic [AW-1:0]        i_addr,
    input  logic [DW-1:0]        i_data,
    output logic                 o_valid,
    input  logic                 i_stall,
    output logic [NS:0]          o_decode,
    output logic [IW-1:0]        o_index,
    output logic [AW-1:0]        o_addr,
    output logic [DW-1:0]        o_data,
    input  logic                 i_resp_done,
    output logic [CW-1:0]        o_outstanding,
    input  logic                 i_err_clear,
    output logic [ERR_CNT_W-1:0] o_err_count
);

    logic [NS-1:0]        hit;
    logic [IW-1:0]        tgt_idx;
    logic [NS:0]          tgt_dec;
    logic                 blocked;
    logic                 accept;
    logic                 drain;
    logic                 resp_eff;

    logic                 out_valid_q, out_valid_d;
    logic [NS:0]          out_dec_q,   out_dec_d;
    logic [IW-1:0]        out_idx_q,   out_idx_d;
    logic [AW-1:0]        out_addr_q,  out_addr_d;
    logic [DW-1:0]        out_data_q,  out_data_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [NS:0]          skid_dec_q,   skid_dec_d;
    logic [IW-1:0]        skid_idx_q,   skid_idx_d;
    logic [AW-1:0]        skid_addr_q,  skid_addr_d;
    logic [DW-1:0]        skid_data_q,  skid_data_d;
    logic [IW-1:0]        cur_target_q, cur_target_d;
    logic [CW-1:0]        cnt_q,        cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,    err_cnt_d;

    // Per-slave match: masked address compare, gated by access permission.
    always_comb begin
        hit = '0;
        for (int k = 0; k < NS; k++) begin
            hit[k] = ((((i_addr ^ SLAVE_ADDR[k]) & SLAVE_MASK[k]) == '0) && ACCESS_ALLOWED[k]);
        end
    end

    // Lowest matching slave wins; no match falls through to the error slave.
    always_comb begin
        logic found;
        found   = 1'b0;
        tgt_idx = IW'(NS);
        tgt_dec = '0;
        for (int k = 0; k < NS; k++) begin
            if (hit[k] && !found) begin
                found      = 1'b1;
                tgt_idx    = IW'(k);
                tgt_dec[k] = 1'b1;
            end
        end
        if (!found) tgt_dec[NS] = 1'b1;
    end

    // A target switch waits for the current slave to drain; a full window waits too.
    assign blocked  = ((cnt_q != '0) && (tgt_idx != cur_target_q)) ||
                      (cnt_q == CW'(MAX_OUTSTANDING));
    assign o_stall  = skid_valid_q | (i_valid & blocked);
    assign accept   = i_valid & ~o_stall;
    assign drain    = ~out_valid_q | ~i_stall;
    assign resp_eff = i_resp_done && (cnt_q != '0);

    // Next-state: output/skid movement, ordering state and error counter.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_dec_d    = out_dec_q;
        out_idx_d    = out_idx_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_dec_d   = skid_dec_q;
        skid_idx_d   = skid_idx_q;
        skid_addr_d  = skid_addr_q;
        skid_data_d  = skid_data_q;
        cur_target_d = cur_target_q;
        cnt_d        = cnt_q;
        err_cnt_d    = err_cnt_q;

        if (drain) begin
            // Skid holds the older request, so it always goes out first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_dec_d    = skid_dec_q;
                out_idx_d    = skid_idx_q;
                out_addr_d   = skid_addr_q;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_dec_d   = tgt_dec;
                out_idx_d   = tgt_idx;
                out_addr_d  = i_addr;
                out_data_d  = i_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_dec_d   = tgt_dec;
            skid_idx_d   = tgt_idx;
            skid_addr_d  = i_addr;
            skid_data_d  = i_data;
        end

        if (accept) cur_target_d = tgt_idx;

        if (accept && !resp_eff)      cnt_d = cnt_q + CW'(1);
        else if (!accept && resp_eff) cnt_d = cnt_q - CW'(1);

        if (i_err_clear)
            err_cnt_d = '0;
        else if (accept && (tgt_idx == IW'(NS)) && !(&err_cnt_q))
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    // State registers; reset drops any in-flight output and skid contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_dec_q    <= '0;
            out_idx_q    <= '0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_dec_q   <= '0;
            skid_idx_q   <= '0;
            skid_addr_q  <= '0;
            skid_data_q  <= '0;
            cur_target_q <= '0;
            cnt_q        <= '0;
            err_cnt_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_dec_q    <= out_dec_d;
            out_idx_q    <= out_idx_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_dec_q   <= skid_dec_d;
            skid_idx_q   <= skid_idx_d;
            skid_addr_q  <= skid_addr_d;
            skid_data_q  <= skid_data_d;
            cur_target_q <= cur_target_d;
            cnt_q        <= cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign o_valid       = out_valid_q;
    assign o_decode      = out_dec_q;
    assign o_index       = out_idx_q;
    assign o_addr        = out_addr_q;
    assign o_data        = out_data_q;
    assign o_outstanding = cnt_q;
    assign o_err_count   = err_cnt_q;

endmodule

// File: tb/tb_axil_ordered_address_router.sv
// Directed bench: three router instances share stimulus; m_* uses the plain
// 4-slave map, v_* gives slave 2 an all-zero mask, e_* denies slave 2.
module tb_axil_ordered_address_router;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_addr = '0;
    logic [37:0] i_data = '0;
    logic        i_stall = 1'b0;
    logic        i_resp_done = 1'b0;
    logic        i_err_clear = 1'b0;

    logic m_stall, m_valid, v_stall, v_valid, e_stall, e_valid;
    logic [4:0]  m_decode, v_decode, e_decode;
    logic [2:0]  m_index, v_index, e_index;
    logic [31:0] m_addr, v_addr, e_addr;
    logic [37:0] m_data, v_data, e_data;
    logic [2:0]  m_out, v_out, e_out;
    logic [15:0] m_err, v_err, e_err;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [3:0][31:0] ADDRS = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};

    always #5 clock = ~clock;

    axil_ordered_address_router #(.SLAVE_ADDR(ADDRS), .SLAVE_MASK({4{32'hF000_0000}})) dut_m (
        .clock(clock), .reset(reset), .i_valid(i_valid), .o_stall(m_stall),
        .i_addr(i_addr), .i_data(i_data), .o_valid(m_valid), .i_stall(i_stall),
        .o_decode(m_decode), .o_index(m_index), .o_addr(m_addr), .o_data(m_data),
        .i_resp_done(i_resp_done), .o_outstanding(m_out),
        .i_err_clear(i_err_clear), .o_err_count(m_err));

    axil_ordered_address_router #(.SLAVE_ADDR(ADDRS),
        .SLAVE_MASK({32'hF000_0000, 32'h0000_0000, 32'hF000_0000, 32'hF000_0000})) dut_v (
        .clock(clock), .reset(reset), .i_valid(i_valid), .o_stall(v_stall),
        .i_addr(i_addr), .i_data(i_data), .o_valid(v_valid), .i_stall(i_stall),
        .o_decode(v_decode), .o_index(v_index), .o_addr(v_addr), .o_data(v_data),
        .i_resp_done(i_resp_done), .o_outstanding(v_out),
        .i_err_clear(i_err_clear), .o_err_count(v_err));

    axil_ordered_address_router #(.SLAVE_ADDR(ADDRS), .SLAVE_MASK({4{32'hF000_0000}}),
        .ACCESS_ALLOWED(4'b1011)) dut_e (
        .clock(clock), .reset(reset), .i_valid(i_valid), .o_stall(e_stall),
        .i_addr(i_addr), .i_data(i_data), .o_valid(e_valid), .i_stall(i_stall),
        .o_decode(e_decode), .o_index(e_index), .o_addr(e_addr), .o_data(e_data),
        .i_resp_done(i_resp_done), .o_outstanding(e_out),
        .i_err_clear(i_err_clear), .o_err_count(e_err));

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        i_valid = 0; i_stall = 0; i_resp_done = 0; i_err_clear = 0;
        i_addr = '0; i_data = '0;
        reset = 1; tick(); tick(); reset = 0;
    endtask

    task automatic test_reset();
        i_valid = 0; i_stall = 0; i_resp_done = 0; i_err_clear = 0;
        reset = 1; tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", m_valid); end
        n_cmp++; if (m_decode !== 5'b0) begin n_bad++; $display("FAIL rst_decode got %b want 00000", m_decode); end
        n_cmp++; if (m_index !== 3'd0) begin n_bad++; $display("FAIL rst_index got %0d want 0", m_index); end
        n_cmp++; if (m_addr !== 32'd0 || m_data !== 38'd0) begin n_bad++; $display("FAIL rst_addr_data got %h/%h want 0/0", m_addr, m_data); end
        n_cmp++; if (m_out !== 3'd0 || m_err !== 16'd0) begin n_bad++; $display("FAIL rst_counts got %0d/%0d want 0/0", m_out, m_err); end
        reset = 0; #1;
        n_cmp++; if (m_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b want 0", m_stall); end
        tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_idle_valid got %b want 0", m_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        do_reset();
        i_resp_done = 1;
        for (int i = 0; i < 8; i++) begin
            a = 32'h1000_0010 + 32'(4 * i);
            i_valid = 1; i_addr = a; i_data = 38'(i); #1;
            n_cmp++; if (m_stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall[%0d] got %b want 0", i, m_stall); end
            tick();
            n_cmp++; if (m_valid !== 1'b1 || m_decode !== 5'b00010 || m_index !== 3'd1)
                begin n_bad++; $display("FAIL b2b_out[%0d] got v=%b d=%b i=%0d want v=1 d=00010 i=1", i, m_valid, m_decode, m_index); end
            n_cmp++; if (m_addr !== a || m_data !== 38'(i))
                begin n_bad++; $display("FAIL b2b_addr[%0d] got %h/%0d want %h/%0d", i, m_addr, m_data, a, i); end
        end
        i_valid = 0; i_resp_done = 0; tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got %b want 0", m_valid); end
    endtask

    task automatic test_overlap();
        do_reset();
        i_valid = 1; i_addr = 32'h3000_0000; tick(); i_valid = 0;
        n_cmp++; if (v_valid !== 1'b1 || v_index !== 3'd2 || v_decode !== 5'b00100)
            begin n_bad++; $display("FAIL ovl_3000 got v=%b i=%0d d=%b want v=1 i=2 d=00100", v_valid, v_index, v_decode); end
        n_cmp++; if (m_index !== 3'd3 || m_decode !== 5'b01000)
            begin n_bad++; $display("FAIL ovl_plain got i=%0d d=%b want i=3 d=01000", m_index, m_decode); end
        i_resp_done = 1; tick(); i_resp_done = 0;
        i_valid = 1; i_addr = 32'h1000_0000; #1;
        n_cmp++; if (v_stall !== 1'b0) begin n_bad++; $display("FAIL ovl_stall got %b want 0", v_stall); end
        tick(); i_valid = 0;
        n_cmp++; if (v_index !== 3'd1 || v_decode !== 5'b00010)
            begin n_bad++; $display("FAIL ovl_1000 got i=%0d d=%b want i=1 d=00010", v_index, v_decode); end
    endtask

    task automatic test_error();
        do_reset();
        i_valid = 1; i_addr = 32'h2000_0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (e_stall !== 1'b0) begin n_bad++; $display("FAIL err_stall[%0d] got %b want 0", i, e_stall); end
            tick();
            n_cmp++; if (e_valid !== 1'b1 || e_decode !== 5'b10000 || e_index !== 3'd4)
                begin n_bad++; $display("FAIL err_route[%0d] got v=%b d=%b i=%0d want v=1 d=10000 i=4", i, e_valid, e_decode, e_index); end
        end
        i_valid = 0;
        n_cmp++; if (e_err !== 16'd3) begin n_bad++; $display("FAIL err_count got %0d want 3", e_err); end
        n_cmp++; if (m_err !== 16'd0) begin n_bad++; $display("FAIL err_allowed_count got %0d want 0", m_err); end
        i_err_clear = 1; tick(); i_err_clear = 0;
        n_cmp++; if (e_err !== 16'd0) begin n_bad++; $display("FAIL err_clear got %0d want 0", e_err); end
        i_valid = 1; i_err_clear = 1; tick(); i_valid = 0; i_err_clear = 0;
        n_cmp++; if (e_err !== 16'd0 || e_valid !== 1'b1)
            begin n_bad++; $display("FAIL err_clear_hit got cnt=%0d v=%b want 0/1", e_err, e_valid); end
        i_resp_done = 1; tick(); i_resp_done = 0;
        i_valid = 1; tick(); i_valid = 0;
        n_cmp++; if (e_err !== 16'd1) begin n_bad++; $display("FAIL err_after_clear got %0d want 1", e_err); end
    endtask

    task automatic test_ordering();
        do_reset();
        i_valid = 1; i_addr = 32'h0000_0100; tick();
        i_addr = 32'h0000_0200; tick();
        i_addr = 32'h1000_0000; #1;
        n_cmp++; if (m_stall !== 1'b1 || m_out !== 3'd2)
            begin n_bad++; $display("FAIL ord_block got stall=%b out=%0d want 1/2", m_stall, m_out); end
        tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL ord_hold_valid got %b want 0", m_valid); end
        i_resp_done = 1; tick();
        n_cmp++; if (m_out !== 3'd1 || m_stall !== 1'b1)
            begin n_bad++; $display("FAIL ord_one_left got out=%0d stall=%b want 1/1", m_out, m_stall); end
        tick(); i_resp_done = 0; #1;
        n_cmp++; if (m_stall !== 1'b0 || m_out !== 3'd0)
            begin n_bad++; $display("FAIL ord_release got stall=%b out=%0d want 0/0", m_stall, m_out); end
        tick(); i_valid = 0;
        n_cmp++; if (m_valid !== 1'b1 || m_index !== 3'd1 || m_addr !== 32'h1000_0000)
            begin n_bad++; $display("FAIL ord_accept got v=%b i=%0d a=%h want 1/1/10000000", m_valid, m_index, m_addr); end
    endtask

    task automatic test_skid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            i_valid = 1; i_addr = 32'h3000_0000 + 32'(16 * i); i_data = 38'(i); tick();
        end
        n_cmp++; if (m_addr !== 32'h3000_0020 || m_out !== 3'd3)
            begin n_bad++; $display("FAIL skid_fill got a=%h out=%0d want 30000020/3", m_addr, m_out); end
        i_stall = 1; i_addr = 32'h3000_0030; i_data = 38'd3; #1;
        n_cmp++; if (m_stall !== 1'b0) begin n_bad++; $display("FAIL skid_take got %b want 0", m_stall); end
        tick();
        i_addr = 32'h3000_0040; i_data = 38'd4; #1;
        n_cmp++; if (m_stall !== 1'b1 || m_out !== 3'd4)
            begin n_bad++; $display("FAIL skid_full got stall=%b out=%0d want 1/4", m_stall, m_out); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (m_valid !== 1'b1 || m_addr !== 32'h3000_0020 || m_data !== 38'd2 || m_index !== 3'd3)
                begin n_bad++; $display("FAIL skid_hold[%0d] got v=%b a=%h d=%0d want 1/30000020/2", i, m_valid, m_addr, m_data); end
        end
        i_stall = 0; tick();
        n_cmp++; if (m_valid !== 1'b1 || m_addr !== 32'h3000_0030 || m_data !== 38'd3)
            begin n_bad++; $display("FAIL skid_drain got v=%b a=%h d=%0d want 1/30000030/3", m_valid, m_addr, m_data); end
        n_cmp++; if (m_stall !== 1'b1) begin n_bad++; $display("FAIL skid_cnt_block got %b want 1", m_stall); end
        i_resp_done = 1; tick(); i_resp_done = 0;
        n_cmp++; if (m_valid !== 1'b0 || m_out !== 3'd3)
            begin n_bad++; $display("FAIL skid_resp got v=%b out=%0d want 0/3", m_valid, m_out); end
        #1;
        n_cmp++; if (m_stall !== 1'b0) begin n_bad++; $display("FAIL skid_reopen got %b want 0", m_stall); end
        tick(); i_valid = 0;
        n_cmp++; if (m_valid !== 1'b1 || m_addr !== 32'h3000_0040 || m_data !== 38'd4)
            begin n_bad++; $display("FAIL skid_last got v=%b a=%h d=%0d want 1/30000040/4", m_valid, m_addr, m_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_valid = 1; i_addr = 32'hF000_0000; i_data = 38'd9; tick();
        i_stall = 1; tick();
        n_cmp++; if (m_err !== 16'd2 || m_out !== 3'd2 || m_valid !== 1'b1)
            begin n_bad++; $display("FAIL rmid_pre got err=%0d out=%0d v=%b want 2/2/1", m_err, m_out, m_valid); end
        i_valid = 0; reset = 1; tick();
        n_cmp++; if (m_valid !== 1'b0 || m_out !== 3'd0 || m_err !== 16'd0 || m_stall !== 1'b0)
            begin n_bad++; $display("FAIL rmid_clear got v=%b out=%0d err=%0d stall=%b want 0/0/0/0", m_valid, m_out, m_err, m_stall); end
        reset = 0; i_stall = 0; tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_no_skid got %b want 0", m_valid); end
        i_valid = 1; i_addr = 32'h1000_0000; #1;
        n_cmp++; if (m_stall !== 1'b0) begin n_bad++; $display("FAIL rmid_fresh_stall got %b want 0", m_stall); end
        tick(); i_valid = 0;
        n_cmp++; if (m_valid !== 1'b1 || m_index !== 3'd1)
            begin n_bad++; $display("FAIL rmid_fresh got v=%b i=%0d want 1/1", m_valid, m_index); end
        tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_idle got %b want 0", m_valid); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_overlap();
        test_error();
        test_ordering();
        test_skid();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
